// File: rtl/load_read_ctrl.sv
// Load read controller: issues one 8-beat INCR AXI read burst per start
// request and steers each returned beat into the 8-word load register bank.
// Words 0-6 carry the mantissa, word 7 carries the exponent.
module load_read_ctrl #(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int LOAD_AXI_ID  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    load_start_i,
    input  logic [AXI_WIDTH_AD-1:0] load_base_addr_i,
    output logic                    load_busy_o,
    output logic                    load_done_o,
    output logic                    load_error_o,

    output logic [AXI_WIDTH_ID-1:0] m_axi_memory_bus_ARID,
    output logic [AXI_WIDTH_AD-1:0] m_axi_memory_bus_ARADDR,
    output logic [7:0]              m_axi_memory_bus_ARLEN,
    output logic [2:0]              m_axi_memory_bus_ARSIZE,
    output logic [1:0]              m_axi_memory_bus_ARBURST,
    output logic                    m_axi_memory_bus_ARVALID,
    input  logic                    m_axi_memory_bus_ARREADY,

    input  logic [1:0]              m_axi_memory_bus_RRESP,
    input  logic                    m_axi_memory_bus_RLAST,
    input  logic                    m_axi_memory_bus_RVALID,
    output logic                    m_axi_memory_bus_RREADY,

    output logic                    load_data_reg_wr_en,
    output logic [2:0]              sel_load_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [AXI_WIDTH_AD-1:0] araddr;
    logic [2:0]              beat_cnt;
    logic                    load_error;
    logic                    beat_acc;
    logic                    beat_last;
    logic                    beat_bad;
    logic                    start_acc;

    // Burst shape is fixed: 8 beats of 32 bits, incrementing. These never
    // depend on state so they are valid even while reset is asserted.
    assign m_axi_memory_bus_ARID    = AXI_WIDTH_ID'(LOAD_AXI_ID);
    assign m_axi_memory_bus_ARLEN   = 8'd7;
    assign m_axi_memory_bus_ARSIZE  = 3'b010;
    assign m_axi_memory_bus_ARBURST = 2'b01;
    assign m_axi_memory_bus_ARADDR  = araddr;

    // A beat is accepted only while DATA drives RREADY; the write enable is
    // the handshake itself so the bank captures RDATA in the same cycle.
    assign start_acc           = (state == IDLE) && load_start_i;
    assign beat_acc            = (state == DATA) && m_axi_memory_bus_RVALID;
    assign load_data_reg_wr_en = beat_acc;
    assign sel_load_data       = beat_cnt;
    assign load_error_o        = load_error;

    // The burst ends on the eighth beat or on an early RLAST, whichever
    // comes first. A premature or missing RLAST, or a non-OKAY response,
    // flags an error but never suppresses the write of that beat.
    assign beat_last = (beat_cnt == 3'd7) || m_axi_memory_bus_RLAST;
    assign beat_bad  = (m_axi_memory_bus_RRESP != 2'b00)
                     || (m_axi_memory_bus_RLAST != (beat_cnt == 3'd7));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state handshake/status outputs.
    always_comb begin
        state_nxt                = state;
        m_axi_memory_bus_ARVALID = 1'b0;
        m_axi_memory_bus_RREADY  = 1'b0;
        load_busy_o              = 1'b1;
        load_done_o              = 1'b0;
        case (state)
            IDLE: begin
                load_busy_o = 1'b0;
                if (load_start_i) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_axi_memory_bus_ARVALID = 1'b1;
                if (m_axi_memory_bus_ARREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_axi_memory_bus_RREADY = 1'b1;
                if (beat_acc && beat_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_done_o = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst address, beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            araddr     <= '0;
            beat_cnt   <= 3'd0;
            load_error <= 1'b0;
        end else if (start_acc) begin
            // Align to the 32-byte burst so all 8 words share one line.
            araddr     <= {load_base_addr_i[AXI_WIDTH_AD-1:5], 5'b0};
            beat_cnt   <= 3'd0;
            load_error <= 1'b0;
        end else if (beat_acc) begin
            beat_cnt <= beat_last ? 3'd0 : beat_cnt + 3'd1;
            if (beat_bad) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_read_ctrl.sv
// Directed bench for load_read_ctrl: one task per scenario, inline checks.
module tb_load_read_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        wr_en;
    logic [2:0]  sel;
    logic [5:0]  ctl;

    int errors = 0;
    int checks = 0;

    load_read_ctrl #(
        .AXI_WIDTH_ID(4),
        .AXI_WIDTH_AD(32),
        .LOAD_AXI_ID (0)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .load_start_i             (start),
        .load_base_addr_i         (base),
        .load_busy_o              (busy),
        .load_done_o              (done),
        .load_error_o             (error),
        .m_axi_memory_bus_ARID    (arid),
        .m_axi_memory_bus_ARADDR  (araddr),
        .m_axi_memory_bus_ARLEN   (arlen),
        .m_axi_memory_bus_ARSIZE  (arsize),
        .m_axi_memory_bus_ARBURST (arburst),
        .m_axi_memory_bus_ARVALID (arvalid),
        .m_axi_memory_bus_ARREADY (arready),
        .m_axi_memory_bus_RRESP   (rresp),
        .m_axi_memory_bus_RLAST   (rlast),
        .m_axi_memory_bus_RVALID  (rvalid),
        .m_axi_memory_bus_RREADY  (rready),
        .load_data_reg_wr_en      (wr_en),
        .sel_load_data            (sel)
    );

    // Control snapshot: {ARVALID, RREADY, wr_en, busy, done, error}
    assign ctl = {arvalid, rready, wr_en, busy, done, error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "bench did not finish in time");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; base = 32'hFFFF_FFFF;
        arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rresp = 2'b11;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL reset_ctl: got %b required %b", ctl, 6'b000000);
        end
        checks++;
        if (sel !== 3'd0 || araddr !== 32'h0) begin
            errors++; $display("FAIL reset_sel_addr: got sel=%0d addr=%h required 0/0", sel, araddr);
        end
        checks++;
        if ({arlen, arsize, arburst} !== {8'd7, 3'b010, 2'b01} || arid !== 4'd0) begin
            errors++; $display("FAIL reset_consts: got len=%h size=%b burst=%b id=%h required 07/010/01/0",
                               arlen, arsize, arburst, arid);
        end
        tick();
        rst_n = 1'b1; start = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_basic();
        tick();
        start = 1'b1; base = 32'h1000_0004; arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL basic_idle: got %b required %b", ctl, 6'b000000);
        end
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100100 || araddr !== 32'h1000_0000) begin
            errors++; $display("FAIL basic_addr: got ctl=%b addr=%h required 100100/10000000", ctl, araddr);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rlast = (b == 7);
            @(negedge clk);
            checks++;
            if (ctl !== 6'b011100 || sel !== 3'(b)) begin
                errors++; $display("FAIL basic_beat%0d: got ctl=%b sel=%0d required 011100/%0d", b, ctl, sel, b);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000110) begin
            errors++; $display("FAIL basic_done: got %b required %b", ctl, 6'b000110);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000 || sel !== 3'd0) begin
            errors++; $display("FAIL basic_after: got ctl=%b sel=%0d required 000000/0", ctl, sel);
        end
    endtask

    task automatic test_arready_stall();
        tick();
        start = 1'b1; base = 32'h2345_6789; arready = 1'b0; rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL stall_idle_rvalid: got %b required %b", ctl, 6'b000000);
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 6'b100100 || araddr !== 32'h2345_6780) begin
                errors++; $display("FAIL stall_wait%0d: got ctl=%b addr=%h required 100100/23456780", i, ctl, araddr);
            end
            tick();
        end
        arready = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100100) begin
            errors++; $display("FAIL stall_hs: got %b required %b", ctl, 6'b100100);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rlast = (b == 7);
            @(negedge clk);
            checks++;
            if (ctl !== 6'b011100 || sel !== 3'(b)) begin
                errors++; $display("FAIL stall_beat%0d: got ctl=%b sel=%0d required 011100/%0d", b, ctl, sel, b);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000110) begin
            errors++; $display("FAIL stall_done: got %b required %b", ctl, 6'b000110);
        end
        tick();
    endtask

    task automatic test_rvalid_gaps();
        int k;
        int writes;
        k = 0; writes = 0;
        start = 1'b1; base = 32'h0000_0040; arready = 1'b1; rvalid = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 20 && k < 8; i++) begin
            rvalid = (i % 2 == 0); rlast = rvalid && (k == 7);
            @(negedge clk);
            checks++;
            if (wr_en !== rvalid || rready !== 1'b1 || sel !== 3'(k)) begin
                errors++; $display("FAIL gaps_cyc%0d: got wr=%b rdy=%b sel=%0d required %b/1/%0d",
                                   i, wr_en, rready, sel, rvalid, k);
            end
            if (wr_en === 1'b1) writes++;
            tick();
            if (rvalid) k++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (writes != 8 || ctl !== 6'b000110) begin
            errors++; $display("FAIL gaps_done: got writes=%0d ctl=%b required 8/000110", writes, ctl);
        end
        tick();
    endtask

    task automatic test_rlast_early();
        start = 1'b1; base = 32'h0000_0080; arready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rlast = (b == 3);
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1 || sel !== 3'(b)) begin
                errors++; $display("FAIL early_beat%0d: got wr=%b sel=%0d required 1/%0d", b, wr_en, sel, b);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000111) begin
            errors++; $display("FAIL early_done: got %b required %b", ctl, 6'b000111);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000001) begin
            errors++; $display("FAIL early_sticky: got %b required %b", ctl, 6'b000001);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b100100) begin
            errors++; $display("FAIL early_restart_clear: got %b required %b", ctl, 6'b100100);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rlast = (b == 7);
            @(negedge clk);
            checks++;
            if (ctl !== 6'b011100 || sel !== 3'(b)) begin
                errors++; $display("FAIL early_rerun%0d: got ctl=%b sel=%0d required 011100/%0d", b, ctl, sel, b);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        tick();
    endtask

    task automatic test_rresp_error();
        start = 1'b1; base = 32'hFFFF_FFFF; arready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (araddr !== 32'hFFFF_FFE0) begin
            errors++; $display("FAIL rresp_addr: got %h required %h", araddr, 32'hFFFF_FFE0);
        end
        tick();
        for (int b = 0; b < 8; b++) begin
            rvalid = 1'b1; rlast = (b == 7); rresp = (b == 5) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (ctl !== {5'b01110, (b > 5)} || sel !== 3'(b)) begin
                errors++; $display("FAIL rresp_beat%0d: got ctl=%b sel=%0d required %b/%0d",
                                   b, ctl, sel, {5'b01110, (b > 5)}, b);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000111) begin
            errors++; $display("FAIL rresp_done: got %b required %b", ctl, 6'b000111);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000001) begin
            errors++; $display("FAIL rresp_sticky: got %b required %b", ctl, 6'b000001);
        end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        start = 1'b1; base = 32'h1234_5678; arready = 1'b1;
        tick();
        tick();
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rlast = 1'b0;
            @(negedge clk);
            checks++;
            if (ctl !== 6'b011100 || sel !== 3'(b)) begin
                errors++; $display("FAIL midrst_beat%0d: got ctl=%b sel=%0d required 011100/%0d", b, ctl, sel, b);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000 || sel !== 3'd0 || araddr !== 32'h0) begin
            errors++; $display("FAIL midrst_reset: got ctl=%b sel=%0d addr=%h required 000000/0/0", ctl, sel, araddr);
        end
        tick();
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (ctl !== 6'b000000) begin
                errors++; $display("FAIL midrst_noar%0d: got %b required %b", i, ctl, 6'b000000);
            end
        end
        rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; arready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        test_reset();
        test_basic();
        test_arready_stall();
        test_rvalid_gaps();
        test_rlast_early();
        test_rresp_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_read_ctrl.md
LOAD_READ_CTRL -- requirements
Module: load_read_ctrl

Interface
REQ-001 SHALL provide parameter AXI_WIDTH_ID, default 4, AXI ID width in bits.
REQ-002 SHALL provide parameter AXI_WIDTH_AD, default 32, AXI address width.
REQ-003 SHALL provide parameter LOAD_AXI_ID, default 0, constant ID driven on ARID.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port load_start_i  input  1  start request; sampled in IDLE only.
REQ-007 SHALL have port load_base_addr_i  input  AXI_WIDTH_AD  burst base byte address; sampled with start.
REQ-008 SHALL have port load_busy_o  output  1  high in any state other than IDLE.
REQ-009 SHALL have port load_done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port load_error_o  output  1  sticky error flag; cleared on accepted start.
REQ-011 SHALL have ports m_axi_memory_bus_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  output  AXI_WIDTH_ID/AXI_WIDTH_AD/8/3/2/1  AXI read-address channel.
REQ-012 SHALL have port m_axi_memory_bus_ARREADY  input  1  address-channel ready.
REQ-013 SHALL have ports m_axi_memory_bus_RRESP/RLAST/RVALID  input  2/1/1  read-response channel; RDATA is not consumed here.
REQ-014 SHALL have port m_axi_memory_bus_RREADY  output  1  read-data ready.
REQ-015 SHALL have port load_data_reg_wr_en  output  1  write enable to the downstream 8-word load register bank.
REQ-016 SHALL have port sel_load_data  output  3  word index of the current beat (0-6 mantissa words, 7 exponent word).

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-018 IDLE -> ADDR when load_start_i=1; SHALL latch {load_base_addr_i[AD-1:5], 5'b0} into ARADDR, clear load_error_o, clear beat counter.
REQ-019 ADDR: ARVALID=1, ARADDR/ARLEN/ARSIZE/ARBURST held stable until ARVALID&ARREADY; then -> DATA.
REQ-020 ARLEN SHALL be constant 8'd7, ARSIZE 3'b010, ARBURST 2'b01 (INCR), ARID LOAD_AXI_ID.
REQ-021 DATA: RREADY=1; beat accepted when RVALID&RREADY.
REQ-022 load_data_reg_wr_en SHALL equal RVALID&RREADY combinationally, same cycle as RDATA valid (zero latency).
REQ-023 sel_load_data SHALL equal the registered beat counter (0..7), incrementing after each accepted beat.
REQ-024 Beat with counter=7 SHALL end the burst: -> DONE; counter wraps to 0.
REQ-025 RLAST=1 on a beat with counter<7 SHALL set load_error_o and end the burst (-> DONE); that beat is still written.
REQ-026 RLAST=0 on beat counter=7 SHALL set load_error_o; burst still ends.
REQ-027 RRESP!=2'b00 on any accepted beat SHALL set load_error_o; beat is still written.
REQ-028 DONE: load_done_o=1 for exactly one cycle, RREADY=0; -> IDLE next cycle.
REQ-029 load_start_i outside IDLE SHALL be ignored (no queuing).
REQ-030 RVALID outside DATA SHALL produce no wr_en (RREADY=0).
REQ-031 Throughput: start-to-done minimum 11 cycles (1 ADDR + 8 beats + DONE + IDLE entry).

Reset
REQ-032 rst_n=0 at a rising edge SHALL force IDLE, ARVALID=0, RREADY=0, load_data_reg_wr_en=0, sel_load_data=0, load_busy_o=0, load_done_o=0, load_error_o=0, ARADDR=0.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse; interconnect is reset by the same rst_n.
REQ-034 ARLEN/ARSIZE/ARBURST/ARID constants SHALL be valid during reset.

Verification
REQ-035 Base 0x1000_0004, ARREADY=1, RVALID=1 every cycle, RLAST on beat 7 -> ARADDR=0x1000_0000, 8 wr_en pulses sel 0..7, done 1 cycle after beat 7, error=0.
REQ-036 ARREADY held low 5 cycles -> ARVALID and ARADDR stable all 5 cycles; no RREADY until handshake.
REQ-037 RVALID toggled 1-0-1 with gaps -> wr_en only on RVALID cycles, sel advances only on accepted beats, still 8 writes.
REQ-038 RLAST on beat 3 -> 4 writes (sel 0..3), error=1, done pulse; next start clears error.
REQ-039 RRESP=2'b10 on beat 5 -> all 8 writes, error=1 sticky after done.
REQ-040 rst_n low during beat 4, start during busy -> IDLE, all outputs at reset values, ignored start produces no AR.
